kb_event_ctrl: RTL and testbench
================================

// Module: kb_event_ctrl
// PURPOSE
//  Controller between the PS/2 receiver (ps2_rx) and the rest of the system.
//  Decodes raw scan bytes (E0 extended prefix, F0 break prefix) into whole key
//  events, buffers them in a 2**W_SIZE-entry show-ahead event FIFO and
//  throttles the receiver via rx_en when the FIFO is full.
//  Consumers pop one complete make/break event per rd_evt pulse.
// PARAMETERS
//  W_SIZE  2      log2 of FIFO depth (default 4 entries)
//  BRK     8'hF0  break prefix byte
//  EXT     8'hE0  extended prefix byte
// PORTS
//  clk             in   1  system clock, all logic on rising edge
//  reset           in   1  asynchronous active-low reset (0 = reset)
//  scan_done_tick  in   1  1-cycle pulse from ps2_rx: scan_code valid
//  scan_code       in   8  received byte from ps2_rx
//  rx_en           out  1  receiver enable to ps2_rx; =~evt_full
//  rd_evt          in   1  pop head event (1-cycle pulse per pop)
//  evt_code        out  8  head event key code (0 when empty)
//  evt_brk         out  1  head event is a break (key release)
//  evt_ext         out  1  head event was E0-prefixed
//  evt_empty       out  1  FIFO empty
//  evt_full        out  1  FIFO holds 2**W_SIZE events
//  overrun         out  1  1-cycle pulse: completed event dropped (FIFO full)
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, ptrs/count=0, evt_empty=1, evt_full=0,
//   rx_en=1, overrun=0, evt_code/evt_brk/evt_ext=0. Reset mid-sequence discards
//   any partially received prefix; FIFO contents are lost.
//  Decode FSM, advances only on scan_done_tick (no tick -> hold state):
//   IDLE: EXT->GOT_EXT; BRK->GOT_BRK (ext=0); other->push {0,0,code}, stay
//   GOT_EXT: EXT->stay; BRK->GOT_BRK (ext=1); other->push {brk0,ext1,code},IDLE
//   GOT_BRK: other->push {brk1,ext flag,code}, IDLE; EXT->GOT_EXT (break
//    discarded, ext=1); BRK->stay GOT_BRK (ext flag kept)
//  ext flag is a register: set on entry to GOT_EXT, cleared on return to IDLE.
//  Push = completed event. Accepted if !evt_full, or evt_full && rd_evt same
//   cycle (pop frees slot first). Otherwise dropped, overrun=1 for that cycle,
//   FSM still returns to IDLE.
//  Latency: tick in cycle N completing an event -> entry written at edge ending
//   N; evt_empty=0 and evt_* valid in cycle N+1.
//  FIFO: show-ahead; evt_* combinationally reflect head entry, forced 0 when
//   empty. rd_evt while empty is ignored (no pointer/count change).
//   Simultaneous push+pop when non-empty: count unchanged, both ptrs advance.
//   Pointers are W_SIZE bits and wrap modulo 2**W_SIZE; count is W_SIZE+1 bits.
//  evt_full = (count==2**W_SIZE); evt_empty = (count==0); rx_en = ~evt_full,
//   all decoded from registered count (no input-to-output comb path except evt_*
//   via head pointer).
//  rx_en low only stops new frames; a frame already in flight may still
//   complete and is handled by the overrun rule.
// TESTING
//  Tick 1C from reset -> cycle after: evt_empty=0, evt_code=1C, brk=0, ext=0.
//  Ticks F0,1C then rd_evt -> head {1C,brk=1,ext=0}; after pop evt_empty=1.
//  Ticks E0,F0,75 -> single entry {75,brk=1,ext=1}; no entries for prefixes.
//  Push 4 makes (W_SIZE=2) -> evt_full=1, rx_en=0; 5th make tick -> overrun
//   pulse 1 cycle, count stays 4; 5th make with rd_evt same cycle -> no overrun,
//   count 4, head advances.
//  Tick E0, drop reset to 0 for 1 cycle, tick 1C -> entry {1C,brk=0,ext=0}.
//  rd_evt with FIFO empty -> evt_empty stays 1; next push/pop sequence of 6
//   events across pointer wrap returns codes in order.

Source files
------------

// File: rtl/kb_event_ctrl.sv
// PS/2 scan-byte decoder: folds E0/F0 prefixes into whole make/break events
// and queues them in a show-ahead FIFO, throttling the receiver when full.
module kb_event_ctrl #(
  parameter int          W_SIZE = 2,
  parameter logic [7:0]  BRK    = 8'hF0,
  parameter logic [7:0]  EXT    = 8'hE0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_done_tick,
  input  logic [7:0]  scan_code,
  output logic        rx_en,
  input  logic        rd_evt,
  output logic [7:0]  evt_code,
  output logic        evt_brk,
  output logic        evt_ext,
  output logic        evt_empty,
  output logic        evt_full,
  output logic        overrun,
  output logic [1:0]  dbg_state
);

  // Handshakes: a byte is offered by scan_done_tick and new frames are only
  // started by ps2_rx while rx_en=1; an event is offered while evt_empty=0 and
  // consumed by a one-cycle rd_evt, which is ignored when evt_empty=1.

  localparam int                DEPTH    = 1 << W_SIZE;
  localparam logic [W_SIZE:0]   FULL_CNT = {1'b1, {W_SIZE{1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GOT_EXT = 2'd1,
    GOT_BRK = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              ext_q, ext_nxt;
  logic              push, push_brk, push_ext;
  logic              push_ok, pop;
  logic [W_SIZE-1:0] wr_ptr, rd_ptr;
  logic [W_SIZE:0]   count;
  logic [9:0]        mem [DEPTH];
  logic [9:0]        head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ext_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ext_q <= ext_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ext_nxt   = ext_q;
    push      = 1'b0;
    push_brk  = 1'b0;
    push_ext  = 1'b0;
    if (scan_done_tick) begin
      case (state)
        IDLE: begin
          if (scan_code == EXT) begin
            state_nxt = GOT_EXT;
            ext_nxt   = 1'b1;
          end else if (scan_code == BRK) begin
            state_nxt = GOT_BRK;
            ext_nxt   = 1'b0;
          end else begin
            push    = 1'b1;
            ext_nxt = 1'b0;
          end
        end
        GOT_EXT: begin
          if (scan_code == EXT) begin
            state_nxt = GOT_EXT;
          end else if (scan_code == BRK) begin
            state_nxt = GOT_BRK;
            ext_nxt   = 1'b1;
          end else begin
            push      = 1'b1;
            push_ext  = 1'b1;
            state_nxt = IDLE;
            ext_nxt   = 1'b0;
          end
        end
        GOT_BRK: begin
          // A stray E0 after F0 abandons the break and restarts as extended.
          if (scan_code == EXT) begin
            state_nxt = GOT_EXT;
            ext_nxt   = 1'b1;
          end else if (scan_code == BRK) begin
            state_nxt = GOT_BRK;
          end else begin
            push      = 1'b1;
            push_brk  = 1'b1;
            push_ext  = ext_q;
            state_nxt = IDLE;
            ext_nxt   = 1'b0;
          end
        end
        default: begin
          state_nxt = IDLE;
          ext_nxt   = 1'b0;
        end
      endcase
    end
  end

  // When full, a same-cycle pop frees the slot the push then reuses.
  assign pop     = rd_evt && (count != '0);
  assign push_ok = push && ((count != FULL_CNT) || rd_evt);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {push_brk, push_ext, scan_code};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && !push_ok;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign evt_empty = (count == '0);
  assign evt_full  = (count == FULL_CNT);
  assign rx_en     = ~evt_full;
  assign head      = mem[rd_ptr];
  assign evt_code  = evt_empty ? 8'h00 : head[7:0];
  assign evt_ext   = evt_empty ? 1'b0  : head[8];
  assign evt_brk   = evt_empty ? 1'b0  : head[9];
  assign dbg_state = state;

endmodule

// File: tb/tb_kb_event_ctrl.sv
// Directed bench for kb_event_ctrl: prefix decoding, FIFO full/overrun,
// mid-sequence reset and pointer wrap.
module tb_kb_event_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scan_done_tick = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       rx_en;
  logic       rd_evt = 1'b0;
  logic [7:0] evt_code;
  logic       evt_brk;
  logic       evt_ext;
  logic       evt_empty;
  logic       evt_full;
  logic       overrun;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  kb_event_ctrl #(.W_SIZE(2)) dut (
    .clk(clk), .reset(reset), .scan_done_tick(scan_done_tick),
    .scan_code(scan_code), .rx_en(rx_en), .rd_evt(rd_evt),
    .evt_code(evt_code), .evt_brk(evt_brk), .evt_ext(evt_ext),
    .evt_empty(evt_empty), .evt_full(evt_full), .overrun(overrun),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] head_val();
    return {6'b0, evt_brk, evt_ext, evt_code};
  endfunction

  task automatic tick(input logic [7:0] code);
    @(negedge clk);
    scan_done_tick = 1'b1;
    scan_code = code;
    @(negedge clk);
    scan_done_tick = 1'b0;
  endtask

  task automatic tick_pop(input logic [7:0] code);
    @(negedge clk);
    scan_done_tick = 1'b1;
    scan_code = code;
    rd_evt = 1'b1;
    @(negedge clk);
    scan_done_tick = 1'b0;
    rd_evt = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    rd_evt = 1'b1;
    @(negedge clk);
    rd_evt = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s observed=queue-empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, head_val(), {6'b0, e});
    end
    pop();
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_empty", 16'(evt_empty), 16'd1);
    check("rst_full", 16'(evt_full), 16'd0);
    check("rst_rx_en", 16'(rx_en), 16'd1);
    check("rst_overrun", 16'(overrun), 16'd0);
    check("rst_head", head_val(), 16'h0000);
    check("rst_state", 16'(dbg_state), 16'd0);
    reset = 1'b1;

    // Plain make, visible the cycle after the tick
    tick(8'h1C);
    check("make_empty", 16'(evt_empty), 16'd0);
    check("make_head", head_val(), 16'h001C);
    pop();
    check("make_popped", 16'(evt_empty), 16'd1);

    // Break
    tick(8'hF0);
    check("brk_prefix_empty", 16'(evt_empty), 16'd1);
    tick(8'h1C);
    check("brk_head", head_val(), 16'h021C);
    check("brk_state", 16'(dbg_state), 16'd0);
    pop();
    check("brk_popped", 16'(evt_empty), 16'd1);

    // Extended break
    tick(8'hE0);
    check("ext_state", 16'(dbg_state), 16'd1);
    tick(8'hF0);
    check("extbrk_state", 16'(dbg_state), 16'd2);
    check("extbrk_prefix_empty", 16'(evt_empty), 16'd1);
    tick(8'h75);
    check("extbrk_head", head_val(), 16'h0375);
    pop();
    check("extbrk_single", 16'(evt_empty), 16'd1);

    // Repeated prefixes and break abandoned by E0
    tick(8'hF0); tick(8'hF0); tick(8'h1C); exp_q.push_back(10'h21C);
    tick(8'hE0); tick(8'hE0); tick(8'h5A); exp_q.push_back(10'h15A);
    tick(8'hF0); tick(8'hE0); tick(8'h70); exp_q.push_back(10'h170);
    pop_check("f0f0_1c");
    pop_check("e0e0_5a");
    pop_check("f0e0_70");
    check("prefix_drained", 16'(evt_empty), 16'd1);

    // Fill, overrun, and push with simultaneous pop while full
    tick(8'h11); tick(8'h22); tick(8'h33); tick(8'h44);
    exp_q.push_back(10'h011); exp_q.push_back(10'h022);
    exp_q.push_back(10'h033); exp_q.push_back(10'h044);
    check("full_flag", 16'(evt_full), 16'd1);
    check("full_rx_en", 16'(rx_en), 16'd0);
    check("full_head", head_val(), 16'h0011);
    tick(8'h55);
    check("ovr_pulse", 16'(overrun), 16'd1);
    check("ovr_full", 16'(evt_full), 16'd1);
    @(negedge clk);
    check("ovr_one_cycle", 16'(overrun), 16'd0);
    tick_pop(8'h66);
    void'(exp_q.pop_front());
    exp_q.push_back(10'h066);
    check("pushpop_no_ovr", 16'(overrun), 16'd0);
    check("pushpop_full", 16'(evt_full), 16'd1);
    pop_check("drain_22");
    check("drain_rx_en", 16'(rx_en), 16'd1);
    pop_check("drain_33");
    pop_check("drain_44");
    pop_check("drain_66");
    check("drain_empty", 16'(evt_empty), 16'd1);

    // Reset discards a pending prefix
    tick(8'hE0);
    check("pre_rst_state", 16'(dbg_state), 16'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_rst_state", 16'(dbg_state), 16'd0);
    tick(8'h1C);
    check("mid_rst_head", head_val(), 16'h001C);
    pop();

    // Pop while empty, then six events across pointer wrap
    pop();
    check("empty_pop_empty", 16'(evt_empty), 16'd1);
    check("empty_pop_head", head_val(), 16'h0000);
    tick(8'hA1); tick(8'hA2); tick(8'hA3);
    exp_q.push_back(10'h0A1); exp_q.push_back(10'h0A2); exp_q.push_back(10'h0A3);
    pop_check("wrap_a1");
    tick(8'hA4); tick(8'hA5);
    exp_q.push_back(10'h0A4); exp_q.push_back(10'h0A5);
    pop_check("wrap_a2");
    pop_check("wrap_a3");
    tick(8'hA6);
    exp_q.push_back(10'h0A6);
    pop_check("wrap_a4");
    pop_check("wrap_a5");
    pop_check("wrap_a6");
    check("wrap_empty", 16'(evt_empty), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
